// File: rtl/fmul_issue.sv
// fmul_issue -- issue/writeback wrapper around an external FP32 multiplier.
//
// Accepts operand pairs, flushes denormal inputs to signed zero, starts the
// multiplier with a one-cycle mul_ready pulse, and tracks each op in an
// in-order tag FIFO. When the multiplier returns, the special-case result
// (NaN / inf / zero) overrides the raw product, and {y, tag} is queued in a
// result FIFO for writeback. A credit counter bounds the ops in flight to
// DEPTH, so neither FIFO can overflow.
//
// Ports
//   clk, rstn                  clock, async active-high reset
//   in_valid/in_ready          operand handshake; in_x1, in_x2, in_tag
//   mul_x1, mul_x2, mul_ready  multiplier operands + start pulse
//   mul_valid, mul_y           multiplier result (any latency >= 0, in order)
//   out_valid/out_ready        writeback handshake; out_y, out_tag
//   err                        sticky: result arrived with nothing issued
module fmul_issue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x1,
  input  logic [31:0]     in_x2,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     mul_x1,
  output logic [31:0]     mul_x2,
  output logic            mul_ready,
  input  logic            mul_valid,
  input  logic [31:0]     mul_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [TAGW-1:0] out_tag,
  output logic            err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            nan1, inf1, zero1;
    logic            nan2, inf2, zero2;
    logic            sgn;
  } tag_ent_t;

  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
  } res_ent_t;

  function automatic logic [31:0] flush(input logic [31:0] x);
    flush = (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
  endfunction

  // ---------------- credit counter ----------------
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept, out_pop;
  logic [TAGW-1:0] op_tag;

  assign accept  = in_valid && in_ready;
  assign out_pop = out_valid && out_ready;
  assign cnt_nxt = cnt + CW'(accept) - CW'(out_pop);

  // ---------------- tag FIFO ----------------
  tag_ent_t        tq_mem [DEPTH];
  logic [AW-1:0]   tq_wp, tq_rp;
  logic [CW-1:0]   tq_cnt;
  tag_ent_t        push_ent, pop_ent;
  logic            tq_empty, pop_ok, tq_wr, tq_rd, err_set;

  // Class is taken from the registered (already flushed) operands.
  always_comb begin
    push_ent       = '0;
    push_ent.tag   = op_tag;
    push_ent.nan1  = (mul_x1[30:23] == 8'hFF) && (mul_x1[22:0] != 23'd0);
    push_ent.inf1  = (mul_x1[30:23] == 8'hFF) && (mul_x1[22:0] == 23'd0);
    push_ent.zero1 = (mul_x1[30:23] == 8'h00);
    push_ent.nan2  = (mul_x2[30:23] == 8'hFF) && (mul_x2[22:0] != 23'd0);
    push_ent.inf2  = (mul_x2[30:23] == 8'hFF) && (mul_x2[22:0] == 23'd0);
    push_ent.zero2 = (mul_x2[30:23] == 8'h00);
    push_ent.sgn   = mul_x1[31] ^ mul_x2[31];
  end

  assign tq_empty = (tq_cnt == '0);
  // A zero-latency result may pop the entry being pushed this same cycle.
  assign pop_ok   = mul_valid && (!tq_empty || mul_ready);
  assign pop_ent  = tq_empty ? push_ent : tq_mem[tq_rp];
  assign tq_wr    = mul_ready && !(tq_empty && pop_ok);
  assign tq_rd    = pop_ok && !tq_empty;
  assign err_set  = mul_valid && tq_empty && !mul_ready;

  // ---------------- fix-up ----------------
  logic [31:0] fix_y;
  logic        any_nan, any_inf, any_zero;

  always_comb begin
    any_nan  = pop_ent.nan1 || pop_ent.nan2;
    any_inf  = pop_ent.inf1 || pop_ent.inf2;
    any_zero = pop_ent.zero1 || pop_ent.zero2;
    fix_y    = mul_y;
    if (any_nan || (any_inf && any_zero)) fix_y = 32'h7FC0_0000;
    else if (any_inf)                     fix_y = {pop_ent.sgn, 8'hFF, 23'd0};
    else if (any_zero)                    fix_y = {pop_ent.sgn, 31'd0};
  end

  // ---------------- result FIFO ----------------
  res_ent_t      rq_mem [DEPTH];
  logic [AW-1:0] rq_wp, rq_rp;
  logic [CW-1:0] rq_cnt;

  assign out_valid = (rq_cnt != '0);
  assign out_y     = out_valid ? rq_mem[rq_rp].y   : '0;
  assign out_tag   = out_valid ? rq_mem[rq_rp].tag : '0;

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt       <= '0;
      in_ready  <= 1'b0;
      mul_ready <= 1'b0;
      mul_x1    <= '0;
      mul_x2    <= '0;
      op_tag    <= '0;
      tq_wp     <= '0;
      tq_rp     <= '0;
      tq_cnt    <= '0;
      rq_wp     <= '0;
      rq_rp     <= '0;
      rq_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      in_ready  <= (cnt_nxt < CW'(DEPTH));
      mul_ready <= accept;
      if (accept) begin
        mul_x1 <= flush(in_x1);
        mul_x2 <= flush(in_x2);
        op_tag <= in_tag;
      end
      if (tq_wr) tq_wp <= tq_wp + AW'(1);
      if (tq_rd) tq_rp <= tq_rp + AW'(1);
      tq_cnt <= tq_cnt + CW'(mul_ready) - CW'(pop_ok);
      if (pop_ok)  rq_wp <= rq_wp + AW'(1);
      if (out_pop) rq_rp <= rq_rp + AW'(1);
      rq_cnt <= rq_cnt + CW'(pop_ok) - CW'(out_pop);
      if (err_set) err <= 1'b1;
    end
  end

  // Storage arrays carry no reset; validity lives in the pointers/counts.
  always_ff @(posedge clk) begin
    if (tq_wr)  tq_mem[tq_wp] <= push_ent;
    if (pop_ok) rq_mem[rq_wp] <= '{y: fix_y, tag: pop_ent.tag};
  end

endmodule

// File: tb/tb_fmul_issue.sv
// Testbench for fmul_issue: directed special-value cases plus randomized
// traffic against a queue-based reference model; the bench also plays the
// multiplier with a configurable fixed latency.
module tb_fmul_issue;
  localparam int DEPTH = 4;
  localparam int TAGW  = 6;

  logic            clk = 1'b0, rstn = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic [31:0]     in_x1 = '0, in_x2 = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic [31:0]     mul_x1, mul_x2, mul_y_drv = '0;
  logic            mul_ready, mul_valid_w;
  logic            mv_model = 1'b0, mv_force = 1'b0;
  logic            out_valid, out_ready = 1'b0, err;
  logic [31:0]     out_y;
  logic [TAGW-1:0] out_tag;

  assign mul_valid_w = mv_model | mv_force;

  fmul_issue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_ready(mul_ready),
    .mul_valid(mul_valid_w), .mul_y(mul_y_drv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_flush(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
  endfunction

  function automatic logic [31:0] ref_y(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] my);
    logic an, ai, az, bn, bi, bz, s;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    az = (a[30:23] == 8'h00);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    bz = (b[30:23] == 8'h00);
    s  = a[31] ^ b[31];
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
    if (ai || bi) return {s, 31'h7F80_0000};
    if (az || bz) return {s, 31'd0};
    return my;
  endfunction

  typedef struct { logic [31:0] f1, f2, y; } plan_t;
  typedef struct { logic [31:0] y; logic [TAGW-1:0] tag; } exp_t;
  typedef struct { int due; logic [31:0] y; } pend_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  pend_t pend_q[$];
  int    lat = 0, cyc = 0, mcnt = 0;
  bit    armed = 0, tog = 0;

  // Multiplier model: checks the issued operands, answers after `lat` cycles.
  always @(posedge clk) begin
    plan_t p;
    armed = !rstn;
    cyc++;
    #1;
    mv_model = 1'b0;
    if (rstn) pend_q.delete();
    else begin
      if (mul_ready) begin
        chk("issue_planned", 32'(plan_q.size() != 0), 32'd1);
        if (plan_q.size() != 0) begin
          p = plan_q.pop_front();
          chk("mul_x1", mul_x1, p.f1);
          chk("mul_x2", mul_x2, p.f2);
          pend_q.push_back('{cyc + lat, p.y});
        end
      end
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        mv_model  = 1'b1;
        mul_y_drv = pend_q[0].y;
        void'(pend_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (tog) out_ready = ~out_ready;
  end

  // Writeback scoreboard and credit model, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      mcnt = 0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mul_ready", 32'(mul_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mul_x1", mul_x1, 32'd0);
      chk("rst_mul_x2", mul_x2, 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
    end else begin
      if (armed) chk("in_ready_credit", 32'(in_ready), 32'(mcnt < DEPTH));
      if (out_valid && out_ready) begin
        chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_y", out_y, e.y);
          chk("out_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      mcnt = mcnt + int'(in_valid && in_ready) - int'(out_valid && out_ready);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [TAGW-1:0] t);
    in_valid = 1'b1; in_x1 = a; in_x2 = b; in_tag = t;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic wait_accept(input logic [31:0] my);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        plan_q.push_back('{ref_flush(in_x1), ref_flush(in_x2), my});
        exp_q.push_back('{ref_y(in_x1, in_x2, my), in_tag});
      end
    end
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAGW-1:0] t, input logic [31:0] my);
    drive_op(a, b, t);
    wait_accept(my);
  endtask

  task automatic drain(input int bound);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin @(negedge clk); i++; end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    sync();
  endtask

  // Single op with out_ready high: check issued x1 and the result at T+2.
  task automatic one(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic [TAGW-1:0] t, input logic [31:0] my,
                     input logic [31:0] exp_mx1, input logic [31:0] exp_out);
    send(a, b, t, my);
    @(negedge clk);
    chk({nm, "_mul_x1"}, mul_x1, exp_mx1);
    @(negedge clk);
    chk({nm, "_out_y"}, out_y, exp_out);
    sync();
  endtask

  function automatic logic [31:0] rnd_op();
    logic       s;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0:       return {s, 8'h00, m};
      1:       return {s, 8'h00, 23'd0};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, m | 23'd1};
      default: return {s, 8'($urandom_range(1, 254)), m};
    endcase
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    sync();
    rstn = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_first_edge", 32'(in_ready), 32'd1);
    sync();

    // Latency with a zero-latency multiplier.
    out_ready = 1'b1;
    send(32'h4000_0000, 32'h4040_0000, 6'd5, 32'h40C0_0000);
    @(negedge clk);
    chk("t1_mul_ready", 32'(mul_ready), 32'd1);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_y", out_y, 32'h40C0_0000);
    chk("t2_out_tag", 32'(out_tag), 32'd5);
    @(negedge clk);
    chk("t3_mul_ready", 32'(mul_ready), 32'd0);
    sync();

    one("nan",     32'h7FC0_0000, 32'h3F80_0000, 6'd6, 32'h3F80_0001, 32'h7FC0_0000, 32'h7FC0_0000);
    one("infzero", 32'h7F80_0000, 32'h0000_0000, 6'd7, 32'h1234_5678, 32'h7F80_0000, 32'h7FC0_0000);
    one("neginf",  32'hFF80_0000, 32'h4000_0000, 6'd8, 32'h1234_5678, 32'hFF80_0000, 32'hFF80_0000);
    one("denorm",  32'h0000_0001, 32'h3F80_0000, 6'd9, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000);
    one("negzero", 32'h8000_0000, 32'h4000_0000, 6'd10, 32'h1, 32'h8000_0000, 32'h8000_0000);
    one("negden",  32'h8040_0000, 32'hC000_0000, 6'd11, 32'h1, 32'h8000_0000, 32'h0000_0000);
    drain(20);

    // Backpressure: four fill the credits, the fifth waits for a pop.
    out_ready = 1'b0;
    for (int t = 1; t <= 4; t++) send({2'b00, 6'($urandom), 24'($urandom)} | 32'h3F80_0000,
                                      32'h4000_0000, 6'(t), $urandom);
    drive_op(32'h3F80_0000, 32'h3F80_0000, 6'd5);
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_head_tag", 32'(out_tag), 32'd1);
    end
    sync();
    out_ready = 1'b1;
    wait_accept(32'h3F80_0000);
    drain(40);

    // Random traffic, 3-cycle multiplier, toggling out_ready.
    lat = 3;
    tog = 1;
    for (int i = 0; i < 40; i++) send(rnd_op(), rnd_op(), 6'($urandom), $urandom);
    drain(400);
    tog = 0;
    out_ready = 1'b1;

    // Reset with two ops in flight.
    send(32'h4000_0000, 32'h4000_0000, 6'd20, 32'h4080_0000);
    send(32'h4040_0000, 32'h4000_0000, 6'd21, 32'h40C0_0000);
    @(negedge clk); #2;
    rstn = 1'b1;
    mv_force = 1'b1;
    plan_q.delete(); exp_q.delete(); pend_q.delete();
    mcnt = 0;
    repeat (3) @(negedge clk);
    sync();
    rstn = 1'b0;
    mv_force = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'(out_valid), 32'd0);
      chk("no_err_after_reset", 32'(err), 32'd0);
    end
    sync();
    mv_force = 1'b1;
    sync();
    mv_force = 1'b0;
    @(negedge clk);
    chk("spurious_err", 32'(err), 32'd1);
    chk("spurious_dropped", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
